// File: rtl/prf_read_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ pending register reads onto one PRF read port.
// Grants are combinational from pending state; a granted slot can refill on the same edge.
module prf_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PRF_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][3:0] req_id,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [PRF_SIZE-1:0]     ready_regs,
    input  logic                    flush,
    output logic                    prf_requesting,
    output logic [3:0]              prf_requested_id,
    output logic [NUM_REQ-1:0]      grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      pend_v_q, pend_v_d;
    logic [NUM_REQ-1:0][3:0] pend_id_q, pend_id_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]      eligible;
    logic [PTR_W-1:0]        win_idx;
    logic [PTR_W-1:0]        scan_idx;
    logic [3:0]              win_id;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = pend_v_q[i] && ready_regs[pend_id_q[i]];
        end
    end

    // Scan offsets from farthest to nearest so the nearest eligible slot to rr_ptr wins.
    always_comb begin
        win_idx        = '0;
        scan_idx       = '0;
        prf_requesting = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (eligible[scan_idx]) begin
                win_idx        = scan_idx;
                prf_requesting = 1'b1;
            end
        end
    end

    always_comb begin
        win_id           = pend_id_q[win_idx];
        prf_requested_id = prf_requesting ? win_id : 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = prf_requesting && eligible[i] && (pend_id_q[i] == win_id);
        end
        req_ready = (~pend_v_q | grant) & {NUM_REQ{~flush}};
    end

    always_comb begin
        pend_v_d  = pend_v_q & ~grant;
        pend_id_d = pend_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pend_v_d[i]  = 1'b1;
                pend_id_d[i] = req_id[i];
            end
        end
        if (flush) begin
            pend_v_d = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (prf_requesting) begin
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v_q  <= '0;
            pend_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: expected grants are queued at issue time and
// matched by an independent monitor whenever the PRF read strobe is high.
module tb_prf_read_arbiter;

    logic            clk;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][3:0] req_id;
    logic [3:0]      req_ready;
    logic [15:0]     ready_regs;
    logic            flush;
    logic            prf_requesting;
    logic [3:0]      prf_requested_id;
    logic [3:0]      grant;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    prf_read_arbiter #(.NUM_REQ(4), .PRF_SIZE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_id           (req_id),
        .req_ready        (req_ready),
        .ready_regs       (ready_regs),
        .flush            (flush),
        .prf_requesting   (prf_requesting),
        .prf_requested_id (prf_requested_id),
        .grant            (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [3:0] id);
        exp_t e;
        e.grant = g;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    // Monitor: every PRF read outside reset must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && prf_requesting) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got grant=%b id=%0d expected no read", grant, prf_requested_id);
            end else begin
                e = exp_q.pop_front();
                if (grant !== e.grant || prf_requested_id !== e.id) begin
                    errors++;
                    $display("FAIL grant_cmp: got grant=%b id=%0d expected grant=%b id=%0d",
                             grant, prf_requested_id, e.grant, e.id);
                end
            end
        end
    end

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_id     = '0;
        ready_regs = 16'hFFFF;
        flush      = 1'b0;
        #2;
        check("rst_requesting", 32'(prf_requesting), 32'd0);
        check("rst_id", 32'(prf_requested_id), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'hF);
        flush = 1'b1;
        #1;
        check("rst_ready_flush", 32'(req_ready), 32'h0);
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Single request, register ready
        req_valid = 4'b0001;
        req_id[0] = 4'd3;
        #1;
        check("single_ready", 32'(req_ready[0]), 32'd1);
        expect_grant(4'b0001, 4'd3);
        tick();
        req_valid = '0;
        tick();
        check("single_empty_req", 32'(prf_requesting), 32'd0);
        check("single_empty_ready", 32'(req_ready), 32'hF);

        // Round-robin over distinct ids from rr_ptr=0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_id    = {4'd4, 4'd3, 4'd2, 4'd1};
        expect_grant(4'b0001, 4'd1);
        expect_grant(4'b0010, 4'd2);
        expect_grant(4'b0100, 4'd3);
        expect_grant(4'b1000, 4'd4);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("rr_drained", 32'(req_ready), 32'hF);

        // Coalescing of identical ids
        req_valid = 4'b1010;
        req_id    = {4'd5, 4'd0, 4'd5, 4'd0};
        expect_grant(4'b1010, 4'd5);
        tick();
        req_valid = '0;
        tick();
        check("coalesce_empty", 32'(req_ready), 32'hF);

        // Not-ready register waits without blocking others
        ready_regs = 16'hFF7F;
        req_valid  = 4'b0101;
        req_id     = {4'd0, 4'd7, 4'd0, 4'd1};
        expect_grant(4'b0001, 4'd1);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("wait_pending", 32'(req_ready), 32'b1011);
        check("wait_no_read", 32'(prf_requesting), 32'd0);
        expect_grant(4'b0100, 4'd7);
        ready_regs = 16'hFFFF;
        tick();
        check("wait_done", 32'(req_ready), 32'hF);

        // Refill on the grant cycle
        req_valid = 4'b0001;
        req_id    = {4'd0, 4'd0, 4'd0, 4'd2};
        expect_grant(4'b0001, 4'd2);
        tick();
        req_id[0] = 4'd9;
        #1;
        check("refill_ready", 32'(req_ready[0]), 32'd1);
        expect_grant(4'b0001, 4'd9);
        tick();
        req_valid = '0;
        tick();
        check("refill_empty", 32'(req_ready), 32'hF);

        // Flush discards pending slots
        ready_regs = 16'h0000;
        req_valid  = 4'b0110;
        req_id     = {4'd0, 4'd6, 4'd4, 4'd0};
        tick();
        req_valid = '0;
        #1;
        check("flush_pre_ready", 32'(req_ready), 32'b1001);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(req_ready), 32'h0);
        tick();
        flush      = 1'b0;
        ready_regs = 16'hFFFF;
        #1;
        check("flush_no_read", 32'(prf_requesting), 32'd0);
        check("flush_ready_after", 32'(req_ready), 32'hF);
        tick();
        tick();

        // Asynchronous reset mid-stream
        ready_regs = 16'h0000;
        req_valid  = 4'b1001;
        req_id     = {4'd8, 4'd0, 4'd0, 4'd3};
        tick();
        req_valid  = '0;
        ready_regs = 16'hFFFF;
        #1;
        check("pre_rst_grant", 32'(grant), 32'b1000);
        check("pre_rst_id", 32'(prf_requested_id), 32'd8);
        rst = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_req", 32'(prf_requesting), 32'd0);
        check("async_rst_id", 32'(prf_requested_id), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'hF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_no_read", 32'(prf_requesting), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
